// File: rtl/pong_match_ctrl.sv
// Pong match controller: start edge detection, frame-timed serve, paddle hit test,
// per-player scoring with one-cycle point pulses and match-over/winner reporting.
module pong_match_ctrl #(
    parameter int c_GAME_WIDTH    = 40,
    parameter int c_COORD_W       = 6,
    parameter int c_PADDLE_HEIGHT = 6,
    parameter int c_SCORE_LIMIT   = 9,
    parameter int c_SCORE_W       = 4,
    parameter int c_SERVE_FRAMES  = 60
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_Game_Start,
    input  logic                 i_Frame_Tick,
    input  logic [c_COORD_W-1:0] i_Ball_X,
    input  logic [c_COORD_W-1:0] i_Ball_Y,
    input  logic [c_COORD_W-1:0] i_Paddle_Y_P1,
    input  logic [c_COORD_W-1:0] i_Paddle_Y_P2,
    output logic                 o_Game_Active,
    output logic [2:0]           o_State,
    output logic [c_SCORE_W-1:0] o_P1_Score,
    output logic [c_SCORE_W-1:0] o_P2_Score,
    output logic                 o_Point_P1,
    output logic                 o_Point_P2,
    output logic                 o_Match_Over,
    output logic                 o_Winner
);

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        SERVE      = 3'b001,
        RUNNING    = 3'b010,
        POINT      = 3'b011,
        MATCH_OVER = 3'b100
    } t_State;

    localparam int c_CNT_W = (c_SERVE_FRAMES > 0) ? $clog2(c_SERVE_FRAMES + 1) : 1;
    localparam logic [c_CNT_W-1:0]   c_SERVE_LOAD = c_CNT_W'(c_SERVE_FRAMES);
    localparam logic [c_COORD_W-1:0] c_P2_COL     = c_COORD_W'(c_GAME_WIDTH - 1);
    localparam logic [c_COORD_W:0]   c_PAD_SPAN   = (c_COORD_W + 1)'(c_PADDLE_HEIGHT - 1);
    localparam logic [c_SCORE_W-1:0] c_LIMIT      = c_SCORE_W'(c_SCORE_LIMIT);

    t_State               r_State;
    logic                 r_Start_D;
    logic [c_CNT_W-1:0]   r_Serve_Cnt;
    logic [c_SCORE_W-1:0] r_P1_Score;
    logic [c_SCORE_W-1:0] r_P2_Score;
    logic                 r_Point_P1;
    logic                 r_Point_P2;
    logic                 r_Winner;
    logic                 r_Scorer;

    logic                 w_Start_Rise;
    logic [c_COORD_W:0]   w_Ball_Y_Ext;
    logic [c_COORD_W:0]   w_P1_Bottom;
    logic [c_COORD_W:0]   w_P2_Bottom;
    logic                 w_P1_Hit;
    logic                 w_P2_Hit;
    logic                 w_P1_Miss;
    logic                 w_P2_Miss;
    logic [c_SCORE_W-1:0] w_Next_Score;

    assign w_Start_Rise = i_Game_Start & ~r_Start_D;

    // Paddle bottom is formed one bit wider so paddles near the last row do not wrap.
    assign w_Ball_Y_Ext = {1'b0, i_Ball_Y};
    assign w_P1_Bottom  = {1'b0, i_Paddle_Y_P1} + c_PAD_SPAN;
    assign w_P2_Bottom  = {1'b0, i_Paddle_Y_P2} + c_PAD_SPAN;
    assign w_P1_Hit     = (i_Paddle_Y_P1 <= i_Ball_Y) && (w_Ball_Y_Ext <= w_P1_Bottom);
    assign w_P2_Hit     = (i_Paddle_Y_P2 <= i_Ball_Y) && (w_Ball_Y_Ext <= w_P2_Bottom);
    assign w_P1_Miss    = (i_Ball_X == '0) && !w_P1_Hit;
    assign w_P2_Miss    = (i_Ball_X == c_P2_COL) && !w_P2_Hit;

    assign w_Next_Score = r_Scorer ? (r_P2_Score + 1'b1) : (r_P1_Score + 1'b1);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_State     <= IDLE;
            r_Start_D   <= 1'b0;
            r_Serve_Cnt <= '0;
            r_P1_Score  <= '0;
            r_P2_Score  <= '0;
            r_Point_P1  <= 1'b0;
            r_Point_P2  <= 1'b0;
            r_Winner    <= 1'b0;
            r_Scorer    <= 1'b0;
        end else begin
            r_Start_D  <= i_Game_Start;
            r_Point_P1 <= 1'b0;
            r_Point_P2 <= 1'b0;
            case (r_State)
                IDLE: begin
                    if (w_Start_Rise) begin
                        r_Serve_Cnt <= c_SERVE_LOAD;
                        r_State     <= SERVE;
                    end
                end
                SERVE: begin
                    if (r_Serve_Cnt == '0) begin
                        r_State <= RUNNING;
                    end else if (i_Frame_Tick) begin
                        r_Serve_Cnt <= r_Serve_Cnt - 1'b1;
                    end
                end
                RUNNING: begin
                    if (w_P1_Miss) begin
                        r_Scorer <= 1'b1;
                        r_State  <= POINT;
                    end else if (w_P2_Miss) begin
                        r_Scorer <= 1'b0;
                        r_State  <= POINT;
                    end
                end
                POINT: begin
                    if (r_Scorer) begin
                        r_P2_Score <= w_Next_Score;
                        r_Point_P2 <= 1'b1;
                    end else begin
                        r_P1_Score <= w_Next_Score;
                        r_Point_P1 <= 1'b1;
                    end
                    if (w_Next_Score == c_LIMIT) begin
                        r_Winner <= r_Scorer;
                        r_State  <= MATCH_OVER;
                    end else begin
                        r_Serve_Cnt <= c_SERVE_LOAD;
                        r_State     <= SERVE;
                    end
                end
                MATCH_OVER: begin
                    if (w_Start_Rise) begin
                        r_P1_Score  <= '0;
                        r_P2_Score  <= '0;
                        r_Winner    <= 1'b0;
                        r_Serve_Cnt <= c_SERVE_LOAD;
                        r_State     <= SERVE;
                    end
                end
                default: r_State <= IDLE;
            endcase
        end
    end

    assign o_State       = r_State;
    assign o_Game_Active = (r_State == RUNNING);
    assign o_Match_Over  = (r_State == MATCH_OVER);
    assign o_P1_Score    = r_P1_Score;
    assign o_P2_Score    = r_P2_Score;
    assign o_Point_P1    = r_Point_P1;
    assign o_Point_P2    = r_Point_P2;
    assign o_Winner      = r_Winner;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl; point pulses are checked against a queue of expected scores.
module tb_pong_match_ctrl;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic       i_Game_Start = 1'b0;
    logic       i_Frame_Tick = 1'b0;
    logic [5:0] i_Ball_X = 6'd20;
    logic [5:0] i_Ball_Y = 6'd20;
    logic [5:0] i_Paddle_Y_P1 = 6'd10;
    logic [5:0] i_Paddle_Y_P2 = 6'd10;
    logic       o_Game_Active;
    logic [2:0] o_State;
    logic [3:0] o_P1_Score;
    logic [3:0] o_P2_Score;
    logic       o_Point_P1;
    logic       o_Point_P2;
    logic       o_Match_Over;
    logic       o_Winner;

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];

    pong_match_ctrl #(
        .c_GAME_WIDTH(40),
        .c_COORD_W(6),
        .c_PADDLE_HEIGHT(6),
        .c_SCORE_LIMIT(9),
        .c_SCORE_W(4),
        .c_SERVE_FRAMES(3)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst_L(i_Rst_L),
        .i_Game_Start(i_Game_Start),
        .i_Frame_Tick(i_Frame_Tick),
        .i_Ball_X(i_Ball_X),
        .i_Ball_Y(i_Ball_Y),
        .i_Paddle_Y_P1(i_Paddle_Y_P1),
        .i_Paddle_Y_P2(i_Paddle_Y_P2),
        .o_Game_Active(o_Game_Active),
        .o_State(o_State),
        .o_P1_Score(o_P1_Score),
        .o_P2_Score(o_P2_Score),
        .o_Point_P1(o_Point_P1),
        .o_Point_P2(o_Point_P2),
        .o_Match_Over(o_Match_Over),
        .o_Winner(o_Winner)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each point pulse must match the oldest queued {pulse_p1, pulse_p2, score}.
    always @(negedge i_Clk) begin
        if (i_Rst_L && (o_Point_P1 || o_Point_P2)) begin
            logic [5:0] obs;
            obs = {o_Point_P1, o_Point_P2, (o_Point_P2 ? o_P2_Score : o_P1_Score)};
            if (exp_q.size() == 0) begin
                check("unexpected_point", {26'd0, obs}, 32'd0);
            end else begin
                check("point_pulse", {26'd0, obs}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic frame_pulse();
        i_Frame_Tick = 1'b1;
        step(1);
        i_Frame_Tick = 1'b0;
        step(1);
    endtask

    task automatic serve_to_run();
        frame_pulse();
        frame_pulse();
        i_Frame_Tick = 1'b1;
        step(1);
        i_Frame_Tick = 1'b0;
        check("serve_last_tick_state", {29'd0, o_State}, 32'd1);
        step(1);
        check("running_state", {29'd0, o_State}, 32'd2);
        check("running_active", {31'd0, o_Game_Active}, 32'd1);
    endtask

    task automatic score(input bit p2, input logic [3:0] new_score);
        serve_to_run();
        if (p2) begin
            i_Paddle_Y_P1 = 6'd10;
            i_Ball_Y = 6'd16;
            i_Ball_X = 6'd0;
        end else begin
            i_Paddle_Y_P2 = 6'd60;
            i_Ball_Y = 6'd0;
            i_Ball_X = 6'd39;
        end
        exp_q.push_back({~p2, p2, new_score});
        step(1);
        check("point_state", {29'd0, o_State}, 32'd3);
        check("point_inactive", {31'd0, o_Game_Active}, 32'd0);
        i_Ball_X = 6'd20;
        step(1);
        check("after_point_state", {29'd0, o_State}, (new_score == 4'd9) ? 32'd4 : 32'd1);
        step(1);
        check("pulse_cleared", {30'd0, o_Point_P1, o_Point_P2}, 32'd0);
    endtask

    initial begin
        // Reset held for two clocks
        step(2);
        check("rst_state", {29'd0, o_State}, 32'd0);
        check("rst_scores", {24'd0, o_P1_Score, o_P2_Score}, 32'd0);
        check("rst_pulses", {30'd0, o_Point_P1, o_Point_P2}, 32'd0);
        check("rst_active", {31'd0, o_Game_Active}, 32'd0);
        check("rst_match", {30'd0, o_Match_Over, o_Winner}, 32'd0);
        i_Rst_L = 1'b1;

        // Held start button gives one SERVE entry
        i_Game_Start = 1'b1;
        step(1);
        check("start_serve", {29'd0, o_State}, 32'd1);
        step(99);
        check("start_held_serve", {29'd0, o_State}, 32'd1);
        check("start_held_cnt", {30'd0, dut.r_Serve_Cnt}, 32'd3);
        i_Game_Start = 1'b0;
        step(1);
        serve_to_run();

        // Start rise while RUNNING is ignored
        i_Game_Start = 1'b1;
        step(3);
        i_Game_Start = 1'b0;
        step(1);
        check("run_start_ignored", {29'd0, o_State}, 32'd2);

        // Inclusive paddle edges on P1 side
        i_Paddle_Y_P1 = 6'd10;
        i_Ball_Y = 6'd10;
        i_Ball_X = 6'd0;
        step(4);
        check("p1_top_hit", {25'd0, o_State, o_P2_Score}, {25'd0, 3'd2, 4'd0});
        i_Ball_Y = 6'd15;
        step(4);
        check("p1_bot_hit", {25'd0, o_State, o_P2_Score}, {25'd0, 3'd2, 4'd0});
        i_Ball_X = 6'd20;
        step(1);

        // Bottom row just past paddle misses: P2 scores; this also leaves state in SERVE
        exp_q.push_back({1'b0, 1'b1, 4'd1});
        i_Ball_Y = 6'd16;
        i_Ball_X = 6'd0;
        step(1);
        check("p1_miss_point", {29'd0, o_State}, 32'd3);
        i_Ball_X = 6'd20;
        step(1);
        check("p2_score_1", {28'd0, o_P2_Score}, 32'd1);
        check("p2_pulse_hi", {30'd0, o_Point_P1, o_Point_P2}, 32'd1);
        check("p2_serve", {29'd0, o_State}, 32'd1);
        step(1);
        check("p2_pulse_lo", {30'd0, o_Point_P1, o_Point_P2}, 32'd0);

        // P2 paddle near bottom: top+height overflows 6 bits, still a hit
        serve_to_run();
        i_Paddle_Y_P2 = 6'd60;
        i_Ball_Y = 6'd63;
        i_Ball_X = 6'd39;
        step(5);
        check("p2_wrap_hit", {21'd0, o_State, o_P1_Score, o_P2_Score}, {21'd0, 3'd2, 4'd0, 4'd1});
        i_Ball_X = 6'd20;
        step(1);
        // Get back to SERVE through a P1 point, then P1 runs to the limit
        exp_q.push_back({1'b1, 1'b0, 4'd1});
        i_Ball_Y = 6'd0;
        i_Ball_X = 6'd39;
        step(2);
        i_Ball_X = 6'd20;
        step(1);
        for (int unsigned k = 2; k <= 9; k++) score(1'b0, 4'(k));
        check("p1_win_scores", {24'd0, o_P1_Score, o_P2_Score}, {24'd0, 4'd9, 4'd1});
        check("p1_win_flags", {30'd0, o_Match_Over, o_Winner}, {30'd0, 1'b1, 1'b0});

        // Frames and misses in MATCH_OVER change nothing
        i_Ball_X = 6'd0;
        i_Ball_Y = 6'd40;
        for (int unsigned k = 0; k < 5; k++) frame_pulse();
        i_Ball_X = 6'd20;
        check("mo_hold", {21'd0, o_State, o_P1_Score, o_P2_Score}, {21'd0, 3'd4, 4'd9, 4'd1});

        // Restart clears scores, then P2 wins
        i_Game_Start = 1'b1;
        step(1);
        i_Game_Start = 1'b0;
        check("restart", {21'd0, o_State, o_P1_Score, o_P2_Score}, {21'd0, 3'd1, 4'd0, 4'd0});
        check("restart_winner", {31'd0, o_Winner}, 32'd0);
        for (int unsigned k = 1; k <= 9; k++) score(1'b1, 4'(k));
        check("p2_win_flags", {30'd0, o_Match_Over, o_Winner}, {30'd0, 1'b1, 1'b1});
        check("p2_win_scores", {24'd0, o_P1_Score, o_P2_Score}, {24'd0, 4'd0, 4'd9});
        i_Game_Start = 1'b1;
        step(1);
        i_Game_Start = 1'b0;
        check("restart2_winner", {28'd0, o_State, o_Winner}, {28'd0, 3'd1, 1'b0});

        // Reset mid-serve with counter at 2
        frame_pulse();
        check("mid_serve_cnt", {30'd0, dut.r_Serve_Cnt}, 32'd2);
        i_Rst_L = 1'b0;
        step(1);
        check("mid_rst_state", {29'd0, o_State}, 32'd0);
        check("mid_rst_cnt", {30'd0, dut.r_Serve_Cnt}, 32'd0);
        i_Rst_L = 1'b1;
        step(2);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
